// File: rtl/tx_share_arbiter_if.sv
// Bundles the producer-side and transmitter-side signals of tx_share_arbiter.
// The slave modport is the arbiter's view; the master modport is the producer/transmitter view.
interface tx_share_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic [N_REQ-1:0]        psel_i;
  logic [N_REQ-1:0]        ack_o;
  logic [N_REQ-1:0]        gnt_o;
  logic                    busy_o;
  logic                    tx_st_o;
  logic [DATA_W-1:0]       tx_d_o;
  logic                    tx_psel_o;
  logic                    tx_eot_i;
  logic                    err_o;

  modport slave (
    input  req_i, data_i, psel_i, tx_eot_i,
    output ack_o, gnt_o, busy_o, tx_st_o, tx_d_o, tx_psel_o, err_o
  );

  modport master (
    output req_i, data_i, psel_i, tx_eot_i,
    input  ack_o, gnt_o, busy_o, tx_st_o, tx_d_o, tx_psel_o, err_o
  );
endinterface

// File: rtl/tx_share_arbiter.sv
// Round-robin share of one serial transmitter; tx_st_o one cycle after the IDLE grant, requesters held off by level req_i until ack_o.
// Transfers are paced by tx_eot_i; optional TX_WATCHDOG_EN aborts a stuck transfer after WD_CYCLES with err_o.
module tx_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int WD_CYCLES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  tx_share_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || WD_CYCLES < 2) begin : g_bad_cfg
    $error("tx_share_arbiter: unsupported N_REQ or WD_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W:0]     w_idx;
  logic               w_found;
  logic               w_any_req;
  logic               w_timeout;
  logic               w_grant;

  logic [N_REQ-1:0]   r_ack;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_busy;
  logic               r_tx_st;
  logic [DATA_W-1:0]  r_tx_d;
  logic               r_tx_psel;
  logic               r_err;

  assign w_any_req = |bus.req_i;

  // First set request at or after r_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(N_REQ)) begin
        w_idx = w_idx - (PTR_W+1)'(N_REQ);
      end
      if (!w_found && bus.req_i[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PTR_W-1:0];
      end
    end
  end

  assign w_ptr_nxt = (r_win == PTR_W'(N_REQ-1)) ? '0 : r_win + 1'b1;

`ifdef TX_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES);
  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_START) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:      if (w_any_req && bus.tx_eot_i) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.tx_eot_i) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.tx_eot_i) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
`ifdef TX_WATCHDOG_EN
    // A stuck transmitter is abandoned through DONE so the pointer still moves on.
    if ((r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) &&
        r_wd_cnt == WD_W'(WD_CYCLES-1)) begin
      w_state_nxt = S_DONE;
      w_timeout   = 1'b1;
    end
`endif
  end

  assign w_grant = (r_state == S_IDLE) && (w_state_nxt == S_START);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are registered from the next state so each one lines up with its state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr     <= '0;
      r_win     <= '0;
      r_ack     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_tx_st   <= 1'b0;
      r_tx_d    <= '0;
      r_tx_psel <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tx_st <= (w_state_nxt == S_START);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_err   <= w_timeout;
      r_ack   <= (w_state_nxt == S_DONE && !w_timeout) ? (N_REQ'(1) << r_win) : '0;
      if (w_grant) begin
        r_win     <= w_win;
        r_tx_d    <= bus.data_i[int'(w_win)*DATA_W +: DATA_W];
        r_tx_psel <= bus.psel_i[w_win];
        r_gnt     <= N_REQ'(1) << w_win;
      end else if (w_state_nxt == S_IDLE) begin
        r_gnt <= '0;
      end
      if (r_state == S_DONE) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign bus.ack_o     = r_ack;
  assign bus.gnt_o     = r_gnt;
  assign bus.busy_o    = r_busy;
  assign bus.tx_st_o   = r_tx_st;
  assign bus.tx_d_o    = r_tx_d;
  assign bus.tx_psel_o = r_tx_psel;
  assign bus.err_o     = r_err;

endmodule
